spi_slave_core: RTL and testbench

- Parametrised SPI slave: configurable word width, SPI mode (CPOL/CPHA) and bit order.
- Adds valid/ready transmit handshake, receive strobe, frame markers and underrun flag.
- Oversamples external sclk/ssel/mosi in the fabric clock domain.
- Sits between the external SPI pins and an internal register/command block.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_sync_edge.sv | 44 ++++
 rtl/spi_slave_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave core:
//   - spi_state_t   : control FSM states
//   - MODE0..MODE3  : SPI mode encodings as {CPOL, CPHA}
//   - bit_cnt_width : width of the in-word bit counter for a given word width
// -----------------------------------------------------------------------------
package spi_pkg;

    // WAIT_DESEL guards against joining a frame mid-way after reset.
    typedef enum logic [1:0] {
        WAIT_DESEL = 2'd0,
        IDLE       = 2'd1,
        ACTIVE     = 2'd2
    } spi_state_t;

    // SPI modes encoded as {CPOL, CPHA}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Bit counter width; never narrower than one bit.
    function automatic int bit_cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings an asynchronous pin into the clk domain through SYNC_STAGES flops and
// produces one-cycle rise/fall strobes from a history flop behind the
// synchroniser.
//
// Ports:
//   clk   in   fabric clock
//   rst   in   synchronous active-high reset
//   din   in   asynchronous pin input
//   dout  out  synchronised level
//   rise  out  one-cycle strobe on synchronised 0->1
//   fall  out  one-cycle strobe on synchronised 1->0
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchroniser chain plus one history flop; the pin enters at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~hist_q;
    assign fall = ~dout & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
// Oversampling SPI slave with configurable word width, mode and bit order.
// Pins are synchronised into clk; all SPI activity is decoded from edge
// strobes, so sclk phases must each last at least SYNC_STAGES+2 clk cycles.
//
// Ports:
//   clk          in   fabric clock
//   rst          in   synchronous active-high reset
//   sclk         in   SPI clock pin (asynchronous)
//   ssel         in   SPI select pin, active low (asynchronous)
//   mosi         in   SPI data in pin
//   miso         out  SPI data out pin, 0 outside a frame
//   rx_data      out  last complete received word
//   rx_valid     out  one-cycle strobe, rx_data updated
//   tx_data      in   next word to transmit
//   tx_valid     in   tx_data offered
//   tx_ready     out  holding register empty
//   tx_underrun  out  one-cycle strobe, word started with empty holding register
//   frame_start  out  one-cycle strobe on synchronised ssel fall
//   frame_end    out  one-cycle strobe on synchronised ssel rise
//   busy         out  FSM in ACTIVE
// -----------------------------------------------------------------------------
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ssel,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int               CNT_W         = bit_cnt_width(WIDTH);
    localparam logic [1:0]       SPI_MODE      = {CPOL[0], CPHA[0]};
    localparam bit               LEAD_FALLS    = (SPI_MODE == MODE2) || (SPI_MODE == MODE3);
    localparam bit               SAMPLE_TRAILS = (SPI_MODE == MODE1) || (SPI_MODE == MODE3);
    localparam bit               MSB_ORDER     = (MSB_FIRST != 0);
    localparam logic [CNT_W-1:0] LAST_BIT      = CNT_W'(WIDTH - 1);

    // Synchronised pins and edge strobes
    logic unused_sclk_level;
    logic sclk_rise, sclk_fall;
    logic ssel_s, ssel_rise, ssel_fall;
    logic mosi_s;
    logic unused_mosi_rise, unused_mosi_fall;

    // Decoded SPI edges
    logic lead_edge, trail_edge, sample_edge, shift_edge;

    // FSM
    spi_state_t state_q, state_d;

    // Control decoded from state and edges
    logic start_d, end_d, sample_en, shift_en, load_en;

    // Datapath registers
    logic [CNT_W-1:0] bit_cnt_q;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic             underrun_q;
    logic             frame_start_q, frame_end_q;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .dout (unused_sclk_level),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ssel_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ssel),
        .dout (ssel_s),
        .rise (ssel_rise),
        .fall (ssel_fall)
    );

    // mosi travels through the same depth as sclk so data lines up with edges.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mosi),
        .dout (mosi_s),
        .rise (unused_mosi_rise),
        .fall (unused_mosi_fall)
    );

    assign lead_edge   = LEAD_FALLS    ? sclk_fall  : sclk_rise;
    assign trail_edge  = LEAD_FALLS    ? sclk_rise  : sclk_fall;
    assign sample_edge = SAMPLE_TRAILS ? trail_edge : lead_edge;
    assign shift_edge  = SAMPLE_TRAILS ? lead_edge  : trail_edge;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_DESEL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ssel is the only thing that moves the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_DESEL: if (ssel_s)    state_d = IDLE;
            IDLE:       if (ssel_fall) state_d = ACTIVE;
            ACTIVE:     if (ssel_rise) state_d = IDLE;
            default:                   state_d = WAIT_DESEL;
        endcase
    end

    // Output/control decode. A deselect in the same cycle as an sclk edge
    // masks the edge. With CPHA=0 the first word is loaded at frame start;
    // afterwards bit_cnt==0 on a shift edge means a word has just completed
    // (CPHA=0) or is about to begin (CPHA=1), so both cases load the shifter.
    always_comb begin
        start_d   = 1'b0;
        end_d     = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        load_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ssel_fall) begin
                    start_d = 1'b1;
                    load_en = !SAMPLE_TRAILS;
                end
            end
            ACTIVE: begin
                if (ssel_rise) begin
                    end_d = 1'b1;
                end else begin
                    sample_en = sample_edge;
                    if (shift_edge) begin
                        if (bit_cnt_q == '0) begin
                            load_en = 1'b1;
                        end else begin
                            shift_en = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign rx_shift_d = MSB_ORDER ? {rx_shift_q[WIDTH-2:0], mosi_s}
                                  : {mosi_s, rx_shift_q[WIDTH-1:1]};
    assign tx_shift_d = MSB_ORDER ? {tx_shift_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, tx_shift_q[WIDTH-1:1]};

    // Receive path: bit counter, shifter and word publication. The completed
    // word is published straight from the shifter's next value so rx_data
    // appears the cycle after the last sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (start_d) begin
                bit_cnt_q <= '0;
            end else if (sample_en) begin
                rx_shift_q <= rx_shift_d;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q  <= '0;
                    rx_data_q  <= rx_shift_d;
                    rx_valid_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // Transmit path: holding register and shifter. A word load sees the
    // holding state from before any same-cycle handshake, so a word accepted
    // while the shifter loads waits for the next word boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (load_en) begin
                tx_shift_q <= hold_full_q ? hold_q : '0;
                underrun_q <= !hold_full_q;
            end else if (shift_en) begin
                tx_shift_q <= tx_shift_d;
            end

            if (load_en && hold_full_q) begin
                hold_full_q <= 1'b0;
            end else if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end
        end
    end

    // Frame strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            frame_start_q <= start_d;
            frame_end_q   <= end_d;
        end
    end

    assign busy        = (state_q == ACTIVE);
    assign miso        = busy ? (MSB_ORDER ? tx_shift_q[WIDTH-1] : tx_shift_q[0]) : 1'b0;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~hold_full_q;
    assign tx_underrun = underrun_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_core
// Four slave instances (mode 0/1/3 at 8 bits MSB first, mode 2 at 16 bits LSB
// first) each driven by its own bit-banged SPI master, with directed words
// and hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_spi_slave_core;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0]       sclk_p;
    logic [3:0]       ssel_p;
    logic [3:0]       mosi_p;
    logic [3:0]       tx_valid_r;
    logic [3:0][15:0] txData;

    wire  [3:0] miso_w, rx_valid_w, tx_ready_w, underrun_w, fs_w, fe_w, busy_w;
    wire  [7:0]  rx0, rx1, rx3;
    wire  [15:0] rx2;

    int cpolTab  [4] = '{0, 0, 1, 1};
    int cphaTab  [4] = '{0, 1, 0, 1};
    int widthTab [4] = '{8, 8, 16, 8};
    int msbTab   [4] = '{1, 1, 0, 1};

    int testCount = 0;
    int failCount = 0;

    int          rxValidCnt [4] = '{default: 0};
    int          fsCnt      [4] = '{default: 0};
    int          feCnt      [4] = '{default: 0};
    int          urCnt      [4] = '{default: 0};
    logic [15:0] rxLog      [4][8];

    always #5 clk = ~clk;

    spi_slave_core #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst(rst), .sclk(sclk_p[0]), .ssel(ssel_p[0]), .mosi(mosi_p[0]),
        .miso(miso_w[0]), .rx_data(rx0), .rx_valid(rx_valid_w[0]),
        .tx_data(txData[0][7:0]), .tx_valid(tx_valid_r[0]), .tx_ready(tx_ready_w[0]),
        .tx_underrun(underrun_w[0]), .frame_start(fs_w[0]), .frame_end(fe_w[0]), .busy(busy_w[0])
    );

    spi_slave_core #(.WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst(rst), .sclk(sclk_p[1]), .ssel(ssel_p[1]), .mosi(mosi_p[1]),
        .miso(miso_w[1]), .rx_data(rx1), .rx_valid(rx_valid_w[1]),
        .tx_data(txData[1][7:0]), .tx_valid(tx_valid_r[1]), .tx_ready(tx_ready_w[1]),
        .tx_underrun(underrun_w[1]), .frame_start(fs_w[1]), .frame_end(fe_w[1]), .busy(busy_w[1])
    );

    spi_slave_core #(.WIDTH(16), .CPOL(1), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst(rst), .sclk(sclk_p[2]), .ssel(ssel_p[2]), .mosi(mosi_p[2]),
        .miso(miso_w[2]), .rx_data(rx2), .rx_valid(rx_valid_w[2]),
        .tx_data(txData[2]), .tx_valid(tx_valid_r[2]), .tx_ready(tx_ready_w[2]),
        .tx_underrun(underrun_w[2]), .frame_start(fs_w[2]), .frame_end(fe_w[2]), .busy(busy_w[2])
    );

    spi_slave_core #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u3 (
        .clk(clk), .rst(rst), .sclk(sclk_p[3]), .ssel(ssel_p[3]), .mosi(mosi_p[3]),
        .miso(miso_w[3]), .rx_data(rx3), .rx_valid(rx_valid_w[3]),
        .tx_data(txData[3][7:0]), .tx_valid(tx_valid_r[3]), .tx_ready(tx_ready_w[3]),
        .tx_underrun(underrun_w[3]), .frame_start(fs_w[3]), .frame_end(fe_w[3]), .busy(busy_w[3])
    );

    function automatic logic [15:0] getRx(input int idx);
        case (idx)
            0:       return {8'h00, rx0};
            1:       return {8'h00, rx1};
            2:       return rx2;
            default: return {8'h00, rx3};
        endcase
    endfunction

    // Strobe monitor: counts every strobe and logs received words in order.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid_w[i]) begin
                if (rxValidCnt[i] < 8) rxLog[i][rxValidCnt[i]] = getRx(i);
                rxValidCnt[i] = rxValidCnt[i] + 1;
            end
            if (fs_w[i])       fsCnt[i] = fsCnt[i] + 1;
            if (fe_w[i])       feCnt[i] = feCnt[i] + 1;
            if (underrun_w[i]) urCnt[i] = urCnt[i] + 1;
        end
    end

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offers one word on the holding-register handshake once tx_ready is up.
    task automatic offerTx(input int idx, input logic [15:0] val);
        int n;
        n = 0;
        while (!tx_ready_w[idx] && n < 200) begin
            waitCyc(1);
            n++;
        end
        checkOutput("txReadyWait", {31'd0, tx_ready_w[idx]}, 32'd1);
        if (tx_ready_w[idx]) begin
            txData[idx]     = val;
            tx_valid_r[idx] = 1'b1;
            waitCyc(1);
            tx_valid_r[idx] = 1'b0;
        end
    endtask

    task automatic spiSelect(input int idx);
        ssel_p[idx] = 1'b0;
        waitCyc(HALF);
    endtask

    // Clocks nBits bits of word. With CPHA=0 and isFinal set, the last bit's
    // trailing edge is withheld until after deselect.
    task automatic spiBits(input int idx, input logic [15:0] word, input int nBits,
                           input bit isFinal, output logic [15:0] misoWord);
        int   pos;
        logic idleLvl;
        idleLvl  = (cpolTab[idx] != 0);
        misoWord = '0;
        for (int k = 0; k < nBits; k++) begin
            pos = (msbTab[idx] != 0) ? widthTab[idx] - 1 - k : k;
            if (cphaTab[idx] == 0) begin
                mosi_p[idx] = word[pos];
                waitCyc(HALF);
                misoWord[pos] = miso_w[idx];
                sclk_p[idx]   = ~idleLvl;
                waitCyc(HALF);
                if (!(isFinal && k == nBits - 1)) sclk_p[idx] = idleLvl;
            end else begin
                sclk_p[idx] = ~idleLvl;
                mosi_p[idx] = word[pos];
                waitCyc(HALF);
                misoWord[pos] = miso_w[idx];
                sclk_p[idx]   = idleLvl;
                waitCyc(HALF);
            end
        end
    endtask

    task automatic spiDeselect(input int idx);
        waitCyc(HALF);
        ssel_p[idx] = 1'b1;
        waitCyc(HALF);
        sclk_p[idx] = (cpolTab[idx] != 0);
        waitCyc(2 * HALF);
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] word, input int nBits,
                                 output logic [15:0] misoWord);
        spiSelect(idx);
        spiBits(idx, word, nBits, 1'b1, misoWord);
        spiDeselect(idx);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] m0, m1;
        int bRx, bFs, bFe, bUr;

        sclk_p     = 4'b1100;
        ssel_p     = 4'b1111;
        mosi_p     = 4'b0000;
        tx_valid_r = 4'b0000;
        txData     = '0;

        // Reset state
        rst = 1'b1;
        waitCyc(4);
        checkOutput("rstMiso",       {31'd0, miso_w[0]},     32'd0);
        checkOutput("rstRxData",     {24'd0, rx0},           32'd0);
        checkOutput("rstRxValid",    {31'd0, rx_valid_w[0]}, 32'd0);
        checkOutput("rstTxReady",    {31'd0, tx_ready_w[0]}, 32'd1);
        checkOutput("rstBusy",       {31'd0, busy_w[0]},     32'd0);
        checkOutput("rstFrameStart", {31'd0, fs_w[0]},       32'd0);
        checkOutput("rstUnderrun",   {31'd0, underrun_w[0]}, 32'd0);
        rst = 1'b0;
        waitCyc(10);

        // Mode 0: preloaded 0x3C, master sends 0xA5
        offerTx(0, 16'h003C);
        checkOutput("A_txReadyLow", {31'd0, tx_ready_w[0]}, 32'd0);
        bRx = rxValidCnt[0]; bFs = fsCnt[0]; bFe = feCnt[0]; bUr = urCnt[0];
        applyStimulus(0, 16'h00A5, 8, m0);
        checkOutput("A_rxCount",   rxValidCnt[0] - bRx, 32'd1);
        checkOutput("A_rxData",    {24'd0, rx0},        32'h00A5);
        checkOutput("A_misoWord",  {16'd0, m0},         32'h003C);
        checkOutput("A_underrun",  urCnt[0] - bUr,      32'd0);
        checkOutput("A_frameStart", fsCnt[0] - bFs,     32'd1);
        checkOutput("A_frameEnd",  feCnt[0] - bFe,      32'd1);
        checkOutput("A_busyAfter", {31'd0, busy_w[0]},  32'd0);
        checkOutput("A_txReadyBack", {31'd0, tx_ready_w[0]}, 32'd1);

        // Mode 3: two back-to-back words, second tx word offered mid-frame
        offerTx(3, 16'h00C0);
        bRx = rxValidCnt[3]; bUr = urCnt[3];
        spiSelect(3);
        fork
            begin
                spiBits(3, 16'h0012, 8, 1'b0, m0);
                spiBits(3, 16'h0034, 8, 1'b1, m1);
            end
            begin
                offerTx(3, 16'h00DE);
            end
        join
        spiDeselect(3);
        checkOutput("B_rxCount",  rxValidCnt[3] - bRx, 32'd2);
        checkOutput("B_rxWord0",  {16'd0, rxLog[3][bRx]},     32'h0012);
        checkOutput("B_rxWord1",  {16'd0, rxLog[3][bRx + 1]}, 32'h0034);
        checkOutput("B_misoWord0", {16'd0, m0},        32'h00C0);
        checkOutput("B_misoWord1", {16'd0, m1},        32'h00DE);
        checkOutput("B_underrun", urCnt[3] - bUr,      32'd0);

        // Mode 1: empty holding register at frame start
        bRx = rxValidCnt[1]; bUr = urCnt[1];
        applyStimulus(1, 16'h0096, 8, m0);
        checkOutput("C_underrun", urCnt[1] - bUr,      32'd1);
        checkOutput("C_misoWord", {16'd0, m0},         32'h0000);
        checkOutput("C_rxCount",  rxValidCnt[1] - bRx, 32'd1);
        checkOutput("C_rxData",   {24'd0, rx1},        32'h0096);

        // Mode 2, 16 bits, LSB first
        bRx = rxValidCnt[2]; bFs = fsCnt[2]; bFe = feCnt[2];
        applyStimulus(2, 16'hBEEF, 16, m0);
        checkOutput("D_rxCount",    rxValidCnt[2] - bRx, 32'd1);
        checkOutput("D_rxData",     {16'd0, rx2},        32'hBEEF);
        checkOutput("D_frameStart", fsCnt[2] - bFs,      32'd1);
        checkOutput("D_frameEnd",   feCnt[2] - bFe,      32'd1);

        // Mode 0: frame aborted after 5 bits, then a clean frame
        bRx = rxValidCnt[0]; bFe = feCnt[0];
        applyStimulus(0, 16'h00FF, 5, m0);
        checkOutput("E_rxCount",  rxValidCnt[0] - bRx, 32'd0);
        checkOutput("E_rxHeld",   {24'd0, rx0},        32'h00A5);
        checkOutput("E_frameEnd", feCnt[0] - bFe,      32'd1);
        bRx = rxValidCnt[0];
        applyStimulus(0, 16'h0081, 8, m0);
        checkOutput("E_rxCountNext", rxValidCnt[0] - bRx, 32'd1);
        checkOutput("E_rxDataNext",  {24'd0, rx0},        32'h0081);

        // Mode 0: reset after 3 bits with ssel held low
        spiSelect(0);
        spiBits(0, 16'h00FF, 3, 1'b0, m0);
        rst = 1'b1;
        waitCyc(3);
        checkOutput("F_rstBusy",   {31'd0, busy_w[0]}, 32'd0);
        checkOutput("F_rstRxData", {24'd0, rx0},       32'd0);
        rst = 1'b0;
        waitCyc(2);
        bRx = rxValidCnt[0]; bFs = fsCnt[0]; bFe = feCnt[0];
        spiBits(0, 16'h00FF, 5, 1'b1, m0);
        spiDeselect(0);
        checkOutput("F_rxCount",    rxValidCnt[0] - bRx, 32'd0);
        checkOutput("F_frameStart", fsCnt[0] - bFs,      32'd0);
        checkOutput("F_frameEnd",   feCnt[0] - bFe,      32'd0);
        checkOutput("F_busy",       {31'd0, busy_w[0]},  32'd0);
        bRx = rxValidCnt[0]; bFs = fsCnt[0];
        applyStimulus(0, 16'h005A, 8, m0);
        checkOutput("F_rxCountNext",    rxValidCnt[0] - bRx, 32'd1);
        checkOutput("F_rxDataNext",     {24'd0, rx0},        32'h005A);
        checkOutput("F_frameStartNext", fsCnt[0] - bFs,      32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
